frequency_measurement_controller: RTL and testbench

//  Sequences the two-tone frequency analyzer through gated measurement windows.

---
 rtl/frequency_measurement_controller.sv | 178 +++++++++++++++++
 tb/tb_frequency_measurement_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_measurement_controller.sv
// Sequences the two-tone analyzer through clear/measure/settle/capture windows
// and presents the captured totals and dominant-tone symbol on a valid/ready handshake.
module frequency_measurement_controller #(
  parameter int unsigned WINDOW_TICKS = 50000,
  parameter int unsigned CLEAR_TICKS  = 2,
  parameter int unsigned MIN_TICKS    = 1000
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  output logic        analyzer_enable,
  output logic        analyzer_clear_n,
  input  logic [31:0] f1_value,
  input  logic [31:0] f2_value,
  output logic [31:0] result_f1,
  output logic [31:0] result_f2,
  output logic [1:0]  symbol,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        overrun,
  output logic        busy,
  output logic [15:0] window_count
);

  localparam int unsigned MAX_TICKS = (WINDOW_TICKS > CLEAR_TICKS) ? WINDOW_TICKS : CLEAR_TICKS;
  localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [TW-1:0] CLR_LOAD = TW'(CLEAR_TICKS - 1);
  localparam logic [TW-1:0] WIN_LOAD = TW'(WINDOW_TICKS - 1);
  localparam logic [31:0]   MIN_VAL  = 32'(MIN_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MEAS,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          enable_q, enable_d;
  logic          clear_n_q, clear_n_d;
  logic [31:0]   result_f1_q, result_f1_d;
  logic [31:0]   result_f2_q, result_f2_d;
  logic [1:0]    symbol_q, symbol_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic [15:0]   window_count_q, window_count_d;
  logic          capture;
  logic [1:0]    symbol_now;

  always_comb begin
    if ((f1_value < MIN_VAL) && (f2_value < MIN_VAL)) symbol_now = 2'd0;
    else if (f1_value > f2_value)                     symbol_now = 2'd1;
    else if (f2_value > f1_value)                     symbol_now = 2'd2;
    else                                              symbol_now = 2'd3;
  end

  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    result_f1_d    = result_f1_q;
    result_f2_d    = result_f2_q;
    symbol_d       = symbol_q;
    valid_d        = valid_q;
    overrun_d      = overrun_q;
    window_count_d = window_count_q;
    capture        = 1'b0;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (start && !stop) begin
          state_d   = S_CLR;
          tick_d    = CLR_LOAD;
          overrun_d = 1'b0;
        end
      end
      S_CLR: begin
        if (stop) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (tick_q == '0) begin
          state_d = S_MEAS;
          tick_d  = WIN_LOAD;
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      S_MEAS: begin
        if (stop) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (tick_q == '0) begin
          state_d = S_SETTLE;
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      S_SETTLE: begin
        state_d = stop ? S_IDLE : S_CAPTURE;
        tick_d  = '0;
      end
      S_CAPTURE: begin
        capture = 1'b1;
        if (continuous && !stop) begin
          state_d = S_CLR;
          tick_d  = CLR_LOAD;
        end else begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase

    if (valid_q && result_ready) valid_d = 1'b0;

    // A capture always wins over a same-cycle handshake; only an unconsumed result counts as overrun.
    if (capture) begin
      result_f1_d    = f1_value;
      result_f2_d    = f2_value;
      symbol_d       = symbol_now;
      valid_d        = 1'b1;
      window_count_d = window_count_q + 16'd1;
      if (valid_q && !result_ready) overrun_d = 1'b1;
    end

    enable_d  = (state_d == S_MEAS);
    clear_n_d = (state_d == S_MEAS) || (state_d == S_SETTLE) || (state_d == S_CAPTURE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q        <= S_IDLE;
      tick_q         <= '0;
      enable_q       <= 1'b0;
      clear_n_q      <= 1'b0;
      result_f1_q    <= '0;
      result_f2_q    <= '0;
      symbol_q       <= '0;
      valid_q        <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
      window_count_q <= '0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      enable_q       <= enable_d;
      clear_n_q      <= clear_n_d;
      result_f1_q    <= result_f1_d;
      result_f2_q    <= result_f2_d;
      symbol_q       <= symbol_d;
      valid_q        <= valid_d;
      overrun_q      <= overrun_d;
      busy_q         <= busy_d;
      window_count_q <= window_count_d;
    end
  end

  assign analyzer_enable  = enable_q;
  assign analyzer_clear_n = clear_n_q;
  assign result_f1        = result_f1_q;
  assign result_f2        = result_f2_q;
  assign symbol           = symbol_q;
  assign result_valid     = valid_q;
  assign overrun          = overrun_q;
  assign busy             = busy_q;
  assign window_count     = window_count_q;

endmodule

// File: tb/tb_frequency_measurement_controller.sv
// Directed bench for frequency_measurement_controller (WINDOW_TICKS=100, CLEAR_TICKS=2, MIN_TICKS=10).
// Start sampled at edge 0: CLR edges 0-1, MEAS edges 2-101, SETTLE 102, CAPTURE 103, valid from edge 104.
module tb_frequency_measurement_controller;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        continuous;
  logic        stop;
  logic        analyzer_enable;
  logic        analyzer_clear_n;
  logic [31:0] f1_value;
  logic [31:0] f2_value;
  logic [31:0] result_f1;
  logic [31:0] result_f2;
  logic [1:0]  symbol;
  logic        result_valid;
  logic        result_ready;
  logic        overrun;
  logic        busy;
  logic [15:0] window_count;

  int errors = 0;
  int checks = 0;
  int exp_wc = 0;

  frequency_measurement_controller #(
    .WINDOW_TICKS(100),
    .CLEAR_TICKS (2),
    .MIN_TICKS   (10)
  ) dut (
    .clock           (clock),
    .clear           (clear),
    .start           (start),
    .continuous      (continuous),
    .stop            (stop),
    .analyzer_enable (analyzer_enable),
    .analyzer_clear_n(analyzer_clear_n),
    .f1_value        (f1_value),
    .f2_value        (f2_value),
    .result_f1       (result_f1),
    .result_f2       (result_f2),
    .symbol          (symbol),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .overrun         (overrun),
    .busy            (busy),
    .window_count    (window_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_enable"},  analyzer_enable, 0);
    check_eq({tag, "_clear_n"}, analyzer_clear_n, 0);
    check_eq({tag, "_f1"},      result_f1, 0);
    check_eq({tag, "_f2"},      result_f2, 0);
    check_eq({tag, "_symbol"},  symbol, 0);
    check_eq({tag, "_valid"},   result_valid, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    check_eq({tag, "_busy"},    busy, 0);
    check_eq({tag, "_wc"},      window_count, 0);
  endtask

  logic [31:0] vec_f1  [4] = '{32'd5, 32'd12, 32'd20, 32'hFFFF_FFFF};
  logic [31:0] vec_f2  [4] = '{32'd8, 32'd30, 32'd20, 32'd0};
  logic [1:0]  vec_sym [4] = '{2'd0,  2'd2,   2'd3,   2'd1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0;
    result_ready = 1'b0; f1_value = '0; f2_value = '0;
    tick(2);
    check_reset_outputs("reset");
    clear = 1'b0;
    tick(1);

    // 1: single window timing
    result_ready = 1'b1; f1_value = 32'd40; f2_value = 32'd5;
    pulse_start();
    check_eq("t1_busy_clr", busy, 1);
    check_eq("t1_clrn_e0", analyzer_clear_n, 0);
    check_eq("t1_en_e0", analyzer_enable, 0);
    tick(1);
    check_eq("t1_clrn_e1", analyzer_clear_n, 0);
    tick(1);
    check_eq("t1_en_e2", analyzer_enable, 1);
    check_eq("t1_clrn_e2", analyzer_clear_n, 1);
    tick(99);
    check_eq("t1_en_e101", analyzer_enable, 1);
    tick(1);
    check_eq("t1_en_e102", analyzer_enable, 0);
    check_eq("t1_clrn_e102", analyzer_clear_n, 1);
    tick(1);
    check_eq("t1_valid_e103", result_valid, 0);
    tick(1);
    exp_wc++;
    check_eq("t1_valid", result_valid, 1);
    check_eq("t1_f1", result_f1, 40);
    check_eq("t1_f2", result_f2, 5);
    check_eq("t1_symbol", symbol, 1);
    check_eq("t1_wc", window_count, exp_wc);
    check_eq("t1_busy_done", busy, 0);
    tick(1);
    check_eq("t1_valid_drop", result_valid, 0);

    // 2: symbol decode
    for (int i = 0; i < 4; i++) begin
      f1_value = vec_f1[i]; f2_value = vec_f2[i];
      pulse_start();
      tick(104);
      exp_wc++;
      check_eq($sformatf("t2_valid_%0d", i), result_valid, 1);
      check_eq($sformatf("t2_symbol_%0d", i), symbol, vec_sym[i]);
      check_eq($sformatf("t2_f1_%0d", i), result_f1, vec_f1[i]);
      tick(1);
    end
    check_eq("t2_wc", window_count, exp_wc);

    // 3: continuous with ready low -> overrun
    result_ready = 1'b0; continuous = 1'b1; f1_value = 32'd40; f2_value = 32'd5;
    pulse_start();
    tick(104);
    exp_wc++;
    check_eq("t3_valid1", result_valid, 1);
    check_eq("t3_ovr1", overrun, 0);
    check_eq("t3_busy_cont", busy, 1);
    continuous = 1'b0; f1_value = 32'd15; f2_value = 32'd50;
    tick(50);
    check_eq("t3_hold_f1", result_f1, 40);
    tick(54);
    exp_wc++;
    check_eq("t3_f1", result_f1, 15);
    check_eq("t3_symbol", symbol, 2);
    check_eq("t3_ovr", overrun, 1);
    check_eq("t3_valid2", result_valid, 1);
    check_eq("t3_busy_end", busy, 0);
    check_eq("t3_wc", window_count, exp_wc);
    result_ready = 1'b1;
    tick(1);
    result_ready = 1'b0;
    check_eq("t3_valid_drop", result_valid, 0);
    check_eq("t3_ovr_sticky", overrun, 1);
    pulse_start();
    check_eq("t3_ovr_cleared", overrun, 0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check_eq("t3_abort_busy", busy, 0);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check_eq("ss_busy", busy, 0);

    // 4: stop mid-MEAS
    result_ready = 1'b1;
    pulse_start();
    tick(52);
    check_eq("t4_en_before", analyzer_enable, 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check_eq("t4_en_after", analyzer_enable, 0);
    check_eq("t4_clrn_after", analyzer_clear_n, 0);
    check_eq("t4_busy", busy, 0);
    tick(60);
    check_eq("t4_valid", result_valid, 0);
    check_eq("t4_wc", window_count, exp_wc);

    // 5: reset mid-MEAS with a pending result
    result_ready = 1'b0; f1_value = 32'd40; f2_value = 32'd5;
    pulse_start();
    tick(104);
    check_eq("t5_valid_pre", result_valid, 1);
    pulse_start();
    tick(10);
    check_eq("t5_en_pre", analyzer_enable, 1);
    clear = 1'b1;
    tick(1);
    check_reset_outputs("t5");
    clear = 1'b0;
    exp_wc = 0;
    result_ready = 1'b1; f1_value = 32'd20; f2_value = 32'd20;
    pulse_start();
    tick(104);
    exp_wc++;
    check_eq("t5_valid", result_valid, 1);
    check_eq("t5_symbol", symbol, 3);
    check_eq("t5_wc", window_count, exp_wc);
    tick(1);

    // 6: capture coincident with handshake
    result_ready = 1'b0; continuous = 1'b1; f1_value = 32'd40; f2_value = 32'd5;
    pulse_start();
    tick(104);
    exp_wc++;
    check_eq("t6_valid1", result_valid, 1);
    continuous = 1'b0; f1_value = 32'd12; f2_value = 32'd30;
    tick(103);
    result_ready = 1'b1;
    tick(1);
    exp_wc++;
    check_eq("t6_valid", result_valid, 1);
    check_eq("t6_f1", result_f1, 12);
    check_eq("t6_f2", result_f2, 30);
    check_eq("t6_symbol", symbol, 2);
    check_eq("t6_ovr", overrun, 0);
    check_eq("t6_wc", window_count, exp_wc);
    tick(1);
    check_eq("t6_valid_drop", result_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
